regfile: RTL

Architectural register file for the Y86 pipelined CPU. It holds the eight program registers. It serves two combinational read ports (srcA, srcB) to the decode stage, where the read data feeds the valA/valB forwarding selectors. It accepts two synchronous write ports (dstE, dstM) from the write-back stage.

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/regfile_rdport.sv | 35 +++
 rtl/regfile.sv | 69 ++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, register ids and helpers for the Y86 register file.
package regfile_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    localparam logic [BYTE_W-1:0] RNONE = 8'h0F;

    typedef enum logic [BYTE_W-1:0] {
        REAX = 8'h00,
        RECX = 8'h01,
        REDX = 8'h02,
        REBX = 8'h03,
        RESP = 8'h04,
        REBP = 8'h05,
        RESI = 8'h06,
        REDI = 8'h07
    } reg_id_e;

    function automatic logic id_valid(input logic [BYTE_W-1:0] id, input int nregs);
        return int'(id) < nregs;
    endfunction

    // An id is an error only when it is neither a real register nor the "no register" marker.
    function automatic logic id_bad(input logic [BYTE_W-1:0] id, input int nregs);
        return !id_valid(id, nregs) && (id != RNONE);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: id decode, out-of-range zeroing and, with
// REGFILE_BYPASS_EN defined, a write-back bypass where valM beats valE.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int IDXW  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic [BYTE_W-1:0]             src_id,
    input  logic [NREGS-1:0][WORD_W-1:0]  regs,
`ifdef REGFILE_BYPASS_EN
    input  logic                          we,
    input  logic [BYTE_W-1:0]             dst_e,
    input  logic [WORD_W-1:0]             val_e,
    input  logic [BYTE_W-1:0]             dst_m,
    input  logic [WORD_W-1:0]             val_m,
`endif
    output logic [WORD_W-1:0]             rdata
);

    always_comb begin
        rdata = '0;
        if (id_valid(src_id, NREGS)) begin
            rdata = regs[src_id[IDXW-1:0]];
`ifdef REGFILE_BYPASS_EN
            // A matching dst is necessarily valid because src_id already is.
            if (we && (dst_e == src_id))
                rdata = val_e;
            if (we && (dst_m == src_id))
                rdata = val_m;
`endif
        end
    end

endmodule

// File: rtl/regfile.sv
// Y86 architectural register file: two combinational reads, two write-back
// writes, sticky bad-id flag. Optional same-cycle bypass via REGFILE_BYPASS_EN.
module regfile
    import regfile_pkg::*;
#(
    parameter logic [WORD_W-1:0] SP_RESET = 32'h0000_0000,
    parameter int                NREGS    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [BYTE_W-1:0]  W_dstE_i,
    input  logic [WORD_W-1:0]  W_valE_i,
    input  logic [BYTE_W-1:0]  W_dstM_i,
    input  logic [WORD_W-1:0]  W_valM_i,
    input  logic [BYTE_W-1:0]  d_srcA_i,
    input  logic [BYTE_W-1:0]  d_srcB_i,
    output logic [WORD_W-1:0]  d_rvalA_o,
    output logic [WORD_W-1:0]  d_rvalB_o,
    output logic               wr_err_o
);

    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NREGS-1:0][WORD_W-1:0] regs;

    // The dstM write is issued last so it wins a same-id collision (popl %esp).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == int'(RESP)) ? SP_RESET : '0;
            wr_err_o <= 1'b0;
        end else if (we_i) begin
            if (id_valid(W_dstE_i, NREGS))
                regs[W_dstE_i[IDXW-1:0]] <= W_valE_i;
            if (id_valid(W_dstM_i, NREGS))
                regs[W_dstM_i[IDXW-1:0]] <= W_valM_i;
            if (id_bad(W_dstE_i, NREGS) || id_bad(W_dstM_i, NREGS))
                wr_err_o <= 1'b1;
        end
    end

    regfile_rdport #(.NREGS(NREGS), .IDXW(IDXW)) u_port_a (
        .src_id (d_srcA_i),
        .regs   (regs),
`ifdef REGFILE_BYPASS_EN
        .we     (we_i),
        .dst_e  (W_dstE_i),
        .val_e  (W_valE_i),
        .dst_m  (W_dstM_i),
        .val_m  (W_valM_i),
`endif
        .rdata  (d_rvalA_o)
    );

    regfile_rdport #(.NREGS(NREGS), .IDXW(IDXW)) u_port_b (
        .src_id (d_srcB_i),
        .regs   (regs),
`ifdef REGFILE_BYPASS_EN
        .we     (we_i),
        .dst_e  (W_dstE_i),
        .val_e  (W_valE_i),
        .dst_m  (W_dstM_i),
        .val_m  (W_valM_i),
`endif
        .rdata  (d_rvalB_o)
    );

endmodule
